tmds_decoder: RTL and testbench



---
 rtl/tmds_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one DVI channel: word alignment plus 10b->8b/control decode.
// Latency: 2 clk_pixel edges from the in_raw word holding the symbol's bit 0 to the out_* registers.
// Backpressure: none; one symbol per cycle, always accepted. Alignment slips are silent and never stall.
//
// Ports:
//   clk_pixel  in   pixel clock, all logic on the rising edge
//   resetn     in   asynchronous active-low reset
//   in_raw     in   [9:0] deserialized bits, in_raw[0] received first, any word alignment
//   out_data   out  [7:0] decoded pixel byte (0 during control periods or while unlocked)
//   out_c      out  [1:0] last control value {C1,C0} (channel 0: {vsync,hsync})
//   out_de     out  data enable, 1 = out_data valid
//   locked     out  symbol alignment established
//   slip       out  [3:0] bit offset of the symbol inside the 20-bit history, 0..9

module tmds_decoder #(
   parameter int unsigned C_lock_count    = 64,
   parameter int unsigned C_search_window = 4096,
   parameter int unsigned C_loss_window   = 2048
) (
   input  logic       clk_pixel,
   input  logic       resetn,
   input  logic [9:0] in_raw,
   output logic [7:0] out_data,
   output logic [1:0] out_c,
   output logic       out_de,
   output logic       locked,
   output logic [3:0] slip
);

   // Counter widths. The run counter must be able to hold C_lock_count itself.
   localparam int RUN_W = $clog2(C_lock_count + 1);
   localparam int TMR_W = (C_search_window > 1) ? $clog2(C_search_window) : 1;
   localparam int GAP_W = (C_loss_window > 1) ? $clog2(C_loss_window) : 1;

   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(C_lock_count);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(C_lock_count - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(C_search_window - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(C_loss_window - 1);

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // DVI control tokens, written q[9:0].
   localparam logic [9:0] TOK_C00 = 10'b1101010100;
   localparam logic [9:0] TOK_C01 = 10'b0010101011;
   localparam logic [9:0] TOK_C10 = 10'b0101010100;
   localparam logic [9:0] TOK_C11 = 10'b1010101011;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [9:0]       r0_q, r1_q;
   logic [0:0]       state_q, state_d;
   logic [3:0]       slip_q, slip_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [1:0]       c_last_q, c_last_d;
   logic [7:0]       out_data_q, out_data_d;
   logic [1:0]       out_c_q, out_c_d;
   logic             out_de_q, out_de_d;

   // ------------------------------------------------------------------
   // Symbol extraction: r1 is the older word, so it occupies the low half
   // of the history and an offset k borrows k bits from the newer word r0.
   // ------------------------------------------------------------------
   logic [19:0] hist;
   logic [9:0]  sym;
   logic [3:0]  slip_inc;

   assign hist     = {r0_q, r1_q};
   assign sym      = 10'(hist >> slip_q);
   assign slip_inc = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;

   // ------------------------------------------------------------------
   // Token detection
   // ------------------------------------------------------------------
   logic       is_ctl;
   logic [1:0] tok_val;

   always_comb begin
      is_ctl  = 1'b1;
      tok_val = 2'b00;
      case (sym)
         TOK_C00: tok_val = 2'b00;
         TOK_C01: tok_val = 2'b01;
         TOK_C10: tok_val = 2'b10;
         TOK_C11: tok_val = 2'b11;
         default: is_ctl  = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Data decode. q[9] says the low byte was inverted for DC balance;
   // q[8] says the transition-minimising stage used XOR (1) or XNOR (0).
   // Anything that is not one of the four tokens decodes as data, so
   // TERC4 and guard bands come out as pixel bytes.
   // ------------------------------------------------------------------
   logic [7:0] dat_v;
   logic [7:0] dat_d;

   always_comb begin
      dat_v    = sym[9] ? ~sym[7:0] : sym[7:0];
      dat_d    = 8'h00;
      dat_d[0] = dat_v[0];
      for (int i = 1; i < 8; i++) begin
         dat_d[i] = sym[8] ? (dat_v[i] ^ dat_v[i-1]) : ~(dat_v[i] ^ dat_v[i-1]);
      end
   end

   // ------------------------------------------------------------------
   // Alignment FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      slip_d  = slip_q;
      run_d   = run_q;
      tmr_d   = tmr_q;
      gap_d   = gap_q;

      case (state_q)
         ST_SEARCH: begin
            // Run counts only back-to-back tokens at the current offset.
            if (is_ctl) begin
               run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
               run_d = '0;
            end
            tmr_d = (tmr_q == TMR_LAST) ? tmr_q : tmr_q + TMR_W'(1);

            // Lock wins over a slip that would fall on the same edge.
            if (is_ctl && (run_q >= RUN_LAST)) begin
               state_d = ST_LOCKED;
               run_d   = '0;
               tmr_d   = '0;
               gap_d   = '0;
            end else if (tmr_q == TMR_LAST) begin
               slip_d = slip_inc;
               run_d  = '0;
               tmr_d  = '0;
            end
         end

         default: begin // ST_LOCKED
            if (is_ctl) begin
               gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
               // Too long without blanking: assume we are mis-aligned and
               // resume searching from the next offset.
               state_d = ST_SEARCH;
               slip_d  = slip_inc;
               run_d   = '0;
               tmr_d   = '0;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output stage. Gating follows the next state so outputs open on the
   // very edge that declares lock and close on the edge that drops it.
   // ------------------------------------------------------------------
   always_comb begin
      c_last_d   = is_ctl ? tok_val : c_last_q;
      out_de_d   = 1'b0;
      out_data_d = 8'h00;
      out_c_d    = 2'b00;
      if (state_d == ST_LOCKED) begin
         out_de_d   = ~is_ctl;
         out_data_d = is_ctl ? 8'h00 : dat_d;
         out_c_d    = c_last_d;
      end
   end

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         r0_q       <= '0;
         r1_q       <= '0;
         state_q    <= ST_SEARCH;
         slip_q     <= '0;
         run_q      <= '0;
         tmr_q      <= '0;
         gap_q      <= '0;
         c_last_q   <= '0;
         out_data_q <= '0;
         out_c_q    <= '0;
         out_de_q   <= 1'b0;
      end else begin
         r0_q       <= in_raw;
         r1_q       <= r0_q;
         state_q    <= state_d;
         slip_q     <= slip_d;
         run_q      <= run_d;
         tmr_q      <= tmr_d;
         gap_q      <= gap_d;
         c_last_q   <= c_last_d;
         out_data_q <= out_data_d;
         out_c_q    <= out_c_d;
         out_de_q   <= out_de_d;
      end
   end

   assign out_data = out_data_q;
   assign out_c    = out_c_q;
   assign out_de   = out_de_q;
   assign locked   = (state_q == ST_LOCKED);
   assign slip     = slip_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, sync tokens, loss, slip wrap, misalignment, async reset.
// Latency: outputs checked 2 edges after the word carrying each symbol; sampled 1 ns after the rising edge.
// Backpressure: none; stimulus is one word per cycle.
`timescale 1ns/100ps

module tb_tmds_decoder;

   logic       clk_pixel = 1'b0;
   logic       resetn    = 1'b0;
   logic [9:0] in_raw    = '0;
   logic [7:0] out_data;
   logic [1:0] out_c;
   logic       out_de;
   logic       locked;
   logic [3:0] slip;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] D00 = 10'b0100000000; // decodes to 0x00

   tmds_decoder dut (
      .clk_pixel (clk_pixel),
      .resetn    (resetn),
      .in_raw    (in_raw),
      .out_data  (out_data),
      .out_c     (out_c),
      .out_de    (out_de),
      .locked    (locked),
      .slip      (slip)
   );

   always #5 clk_pixel = ~clk_pixel;

   // Stream state: symbols are laid on the wire shift_amt bits into each word.
   logic [9:0] prev_sym  = '0;
   int         shift_amt = 0;
   logic [7:0] hist_byte [3];
   logic       hist_ctl  [3];
   int         enc_cnt   = 0;

   task automatic push(input logic [9:0] s, input logic ctl, input logic [7:0] byt);
      logic [19:0] cat;
      cat = {s, prev_sym};
      @(negedge clk_pixel);
      in_raw   = 10'(cat >> (10 - shift_amt));
      prev_sym = s;
      hist_byte[2] = hist_byte[1]; hist_byte[1] = hist_byte[0]; hist_byte[0] = byt;
      hist_ctl[2]  = hist_ctl[1];  hist_ctl[1]  = hist_ctl[0];  hist_ctl[0]  = ctl;
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic push_n(input logic [9:0] s, input int n);
      for (int i = 0; i < n; i++) push(s, 1'b1, 8'h00);
   endtask

   // Reference DVI 8b/10b encoder with running disparity.
   task automatic encode(input logic [7:0] d, output logic [9:0] qo);
      int n1d, n1q, n0q;
      logic [8:0] qm;
      n1d   = $countones(d);
      qm    = '0;
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         qo = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         if (qm[8]) enc_cnt = enc_cnt + n1q - n0q;
         else       enc_cnt = enc_cnt + n0q - n1q;
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         qo      = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt = enc_cnt + 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         qo      = {1'b0, qm[8], qm[7:0]};
         enc_cnt = enc_cnt - 2 * int'(~qm[8]) + n1q - n0q;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_pixel);
      resetn    = 1'b0;
      in_raw    = '0;
      prev_sym  = '0;
      shift_amt = 0;
      for (int i = 0; i < 3; i++) begin hist_byte[i] = '0; hist_ctl[i] = 1'b1; end
      @(posedge clk_pixel);
      @(posedge clk_pixel);
      #1;
      @(negedge clk_pixel);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk_pixel);
      resetn = 1'b0;
      @(posedge clk_pixel);
      @(posedge clk_pixel);
      #1;
      checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL rst_locked got %0b want 0", locked); end
      checks++; if (slip !== 4'd0)      begin errors++; $display("FAIL rst_slip got %0d want 0", slip); end
      checks++; if (out_de !== 1'b0)    begin errors++; $display("FAIL rst_de got %0b want 0", out_de); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 00", out_data); end
      checks++; if (out_c !== 2'b00)    begin errors++; $display("FAIL rst_c got %0b want 00", out_c); end
      do_reset();
   endtask

   // 100 aligned c=00 tokens, then hand-decoded data words.
   task automatic test_aligned_lock();
      for (int k = 1; k <= 100; k++) begin
         push(T00, 1'b1, 8'h00);
         if (k == 65) begin
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", locked); end
         end
         if (k == 66) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise got %0b want 1", locked); end
            checks++; if (out_de !== 1'b0 || out_c !== 2'b00)
               begin errors++; $display("FAIL lock_out got de=%0b c=%0b want de=0 c=00", out_de, out_c); end
         end
      end
      push(D00, 1'b0, 8'h00);            // #101
      push(10'b1000000000, 1'b0, 8'hFF); // #102
      checks++; if (out_de !== 1'b0) begin errors++; $display("FAIL latency_hold got de=%0b want 0", out_de); end
      push(10'b0100000001, 1'b0, 8'h03); // #103 -> D00 visible
      checks++; if (out_de !== 1'b1 || out_data !== 8'h00 || out_c !== 2'b00)
         begin errors++; $display("FAIL data_00 got de=%0b d=%0h c=%0b want 1/00/00", out_de, out_data, out_c); end
      push(10'b0000000000, 1'b0, 8'hFE);
      checks++; if (out_de !== 1'b1 || out_data !== 8'hFF)
         begin errors++; $display("FAIL data_ff got de=%0b d=%0h want 1/ff", out_de, out_data); end
      push(T00, 1'b1, 8'h00);
      checks++; if (out_de !== 1'b1 || out_data !== 8'h03)
         begin errors++; $display("FAIL data_03 got de=%0b d=%0h want 1/03", out_de, out_data); end
      push(T00, 1'b1, 8'h00);
      checks++; if (out_de !== 1'b1 || out_data !== 8'hFE)
         begin errors++; $display("FAIL data_fe got de=%0b d=%0h want 1/fe", out_de, out_data); end
   endtask

   task automatic test_sync_decode();
      logic [9:0] seq   [7];
      logic [1:0] exp_c [7];
      logic       exp_de[7];
      seq = '{T00, T01, T10, T11, D00, D00, D00};
      exp_c  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      exp_de = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         push(seq[i], ~exp_de[i], 8'h00);
         if (i >= 2) begin
            checks++;
            if (out_c !== exp_c[i-2] || out_de !== exp_de[i-2] || out_data !== 8'h00) begin
               errors++;
               $display("FAIL sync_%0d got c=%0b de=%0b d=%0h want c=%0b de=%0b d=00",
                        i - 2, out_c, out_de, out_data, exp_c[i-2], exp_de[i-2]);
            end
         end
      end
   endtask

   task automatic test_loss();
      push_n(T00, 2);
      for (int j = 1; j <= 2050; j++) begin
         push(D00, 1'b0, 8'h00);
         if (j == 2049) begin
            checks++; if (locked !== 1'b1 || out_de !== 1'b1)
               begin errors++; $display("FAIL loss_early got lk=%0b de=%0b want 1/1", locked, out_de); end
         end
      end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_lock got %0b want 0", locked); end
      checks++; if (slip !== 4'd1)   begin errors++; $display("FAIL loss_slip got %0d want 1", slip); end
      checks++; if (out_de !== 1'b0 || out_data !== 8'h00 || out_c !== 2'b00)
         begin errors++; $display("FAIL loss_gate got de=%0b d=%0h c=%0b want 0/00/00", out_de, out_data, out_c); end
   endtask

   // Aligned tokens only match at offset 0, so the search must walk 1..9 and wrap.
   task automatic test_slip_wrap();
      for (int k = 1; k <= 9; k++) begin
         push_n(T00, 4095);
         checks++; if (slip !== 4'(k))
            begin errors++; $display("FAIL wrap_hold_%0d got %0d want %0d", k, slip, k); end
         push_n(T00, 1);
         checks++; if (slip !== 4'((k + 1) % 10))
            begin errors++; $display("FAIL wrap_step_%0d got %0d want %0d", k, slip, (k + 1) % 10); end
      end
      push_n(T00, 63);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL wrap_early got %0b want 0", locked); end
      push_n(T00, 1);
      checks++; if (locked !== 1'b1 || slip !== 4'd0)
         begin errors++; $display("FAIL wrap_relock got lk=%0b slip=%0d want 1/0", locked, slip); end
   endtask

   task automatic test_misaligned();
      logic [9:0] s;
      logic [7:0] b;
      logic       seen, done;
      int         checked, line;
      do_reset();
      shift_amt = 3;
      seen = 1'b0; done = 1'b0; checked = 0; line = 0;
      while (!done && line < 20) begin
         for (int p = 0; p < 800 && !done; p++) begin
            if (p < 160) begin
               enc_cnt = 0;
               push(T01, 1'b1, 8'h00);
            end else begin
               b = 8'($urandom_range(255));
               encode(b, s);
               push(s, 1'b0, b);
            end
            if (locked === 1'b1) seen = 1'b1;
            if (seen) begin
               checks++;
               if (out_de !== ~hist_ctl[2] || out_data !== (hist_ctl[2] ? 8'h00 : hist_byte[2]) || out_c !== 2'b01) begin
                  errors++;
                  $display("FAIL mis_decode got de=%0b d=%0h c=%0b want de=%0b d=%0h c=01",
                           out_de, out_data, out_c, ~hist_ctl[2], (hist_ctl[2] ? 8'h00 : hist_byte[2]));
               end
               checked++;
               if (checked >= 800 && !hist_ctl[2]) done = 1'b1;
            end
         end
         line++;
      end
      checks++; if (!seen) begin errors++; $display("FAIL mis_lock_timeout got unlocked want locked"); end
      checks++; if (slip !== 4'd3 || locked !== 1'b1)
         begin errors++; $display("FAIL mis_slip got slip=%0d lk=%0b want 3/1", slip, locked); end
   endtask

   task automatic test_async_reset();
      checks++; if (out_de !== 1'b1) begin errors++; $display("FAIL ar_pre_de got %0b want 1", out_de); end
      #2;
      resetn = 1'b0;
      #0.5;
      checks++; if (locked !== 1'b0 || slip !== 4'd0)
         begin errors++; $display("FAIL ar_state got lk=%0b slip=%0d want 0/0", locked, slip); end
      checks++; if (out_de !== 1'b0 || out_data !== 8'h00 || out_c !== 2'b00)
         begin errors++; $display("FAIL ar_out got de=%0b d=%0h c=%0b want 0/00/00", out_de, out_data, out_c); end
      #0.5;
      resetn    = 1'b1;
      shift_amt = 0;
      prev_sym  = '0;
      push_n(T00, 65);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ar_early got %0b want 0", locked); end
      push_n(T00, 1);
      checks++; if (locked !== 1'b1 || out_c !== 2'b00)
         begin errors++; $display("FAIL ar_relock got lk=%0b c=%0b want 1/00", locked, out_c); end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin hist_byte[i] = '0; hist_ctl[i] = 1'b1; end
      test_reset();
      test_aligned_lock();
      test_sync_decode();
      test_loss();
      test_slip_wrap();
      test_misaligned();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
